// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and frame constants for the UART transmit arbiter
package uart_pkg;
    typedef enum logic [3:0] {
        IDLE     = 4'b0001,
        ISSUE    = 4'b0010,
        WAITBUSY = 4'b0100,
        WAITDONE = 4'b1000
    } state_t;
    localparam int FRAME_BITS = 10;
    localparam int OVERSAMPLE = 16;
endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester/transmitter bus of the arbiter; lock exists only with UART_TX_ARB_LOCK_EN
interface uart_tx_arb_if #(parameter int NREQ = 4);
    localparam int W = $clog2(NREQ);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] chars;
    logic [NREQ-1:0]   ack;
    logic [7:0]        char;
    logic              sendchar;
    logic              busy;
    logic [W-1:0]      owner;
    logic              active;
    logic              drop;
`ifdef UART_TX_ARB_LOCK_EN
    logic [NREQ-1:0]   lock;
`endif
    modport master (
        input  req, chars, busy,
`ifdef UART_TX_ARB_LOCK_EN
        input  lock,
`endif
        output ack, char, sendchar, owner, active, drop
    );
    modport slave (
        output req, chars, busy,
`ifdef UART_TX_ARB_LOCK_EN
        output lock,
`endif
        input  ack, char, sendchar, owner, active, drop
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first set request bit scanning from ptr upward with wrap at NREQ
module rr_pick #(
    parameter int NREQ = 4,
    parameter int W    = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [W-1:0]    ptr,
    output logic            found,
    output logic [W-1:0]    idx
);
    logic [W-1:0] j;
    // scan from the far end back toward ptr so the closest set bit wins
    always_comb begin
        found = |req;
        idx   = '0;
        j     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % NREQ);
            if (req[j]) idx = j;
        end
    end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin sharing of one UART byte transmitter; UART_TX_ARB_LOCK_EN adds owner lock
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int BUSY_TMO = 4
) (
    input logic           clk,
    input logic           reset,
    uart_tx_arb_if.master bus
);
    localparam int W  = $clog2(NREQ);
    localparam int TW = $clog2(BUSY_TMO + 1);

    state_t          state;
    logic [W-1:0]    ptr;
    logic [TW-1:0]   timer;
    logic [NREQ-1:0] cand;
    logic            found;
    logic [W-1:0]    idx;
    logic [W-1:0]    nxt;
    logic            done;
    logic            locked;

    // frame over: busy fell while waiting for it, or it never rose in time
    assign done = !bus.busy && (state == WAITDONE || (state == WAITBUSY && timer <= TW'(1)));
    assign nxt  = (bus.owner == W'(NREQ - 1)) ? '0 : bus.owner + 1'b1;

`ifdef UART_TX_ARB_LOCK_EN
    assign cand = locked ? (bus.req & (NREQ'(1) << bus.owner)) : bus.req;

    // lock is sampled only when a frame ends, so it holds across the next grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) locked <= 1'b0;
        else if (done) locked <= bus.lock[bus.owner];
    end
`else
    assign cand   = bus.req;
    assign locked = 1'b0;
`endif

    rr_pick #(.NREQ(NREQ), .W(W)) u_pick (
        .req  (cand),
        .ptr  (ptr),
        .found(found),
        .idx  (idx)
    );

    // grant, strobe, then follow transmitter busy until the frame ends or times out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            ptr          <= '0;
            timer        <= '0;
            bus.char     <= '0;
            bus.sendchar <= 1'b0;
            bus.ack      <= '0;
            bus.owner    <= '0;
            bus.active   <= 1'b0;
            bus.drop     <= 1'b0;
        end else begin
            bus.sendchar <= 1'b0;
            bus.ack      <= '0;
            bus.drop     <= 1'b0;
            case (state)
                IDLE: if (found && !bus.busy) begin
                    bus.owner    <= idx;
                    bus.char     <= bus.chars[8*idx +: 8];
                    bus.active   <= 1'b1;
                    bus.sendchar <= 1'b1;
                    bus.ack      <= NREQ'(1) << idx;
                    state        <= ISSUE;
                end
                ISSUE: begin
                    ptr   <= locked ? ptr : nxt;
                    timer <= TW'(BUSY_TMO);
                    state <= WAITBUSY;
                end
                WAITBUSY: begin
                    timer      <= timer - 1'b1;
                    bus.drop   <= done;
                    bus.active <= !done;
                    state      <= bus.busy ? WAITDONE : done ? IDLE : WAITBUSY;
                end
                WAITDONE: begin
                    bus.active <= !done;
                    state      <= done ? IDLE : WAITDONE;
                end
                default: begin
                    bus.active <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter sharing one UART byte transmitter (char/sendchar/busy interface, 10-bit frame) between NREQ requesters.
- Each requester presents a byte with a level request.
- The arbiter picks a winner, issues a one-cycle sendchar with the winner's byte, and tracks transmitter busy until the frame completes.
- Only then does it grant the next requester.

Parameters:
- NREQ, 4, number of requesters, 2..8.
- BUSY_TMO, 4, cycles allowed after sendchar for busy to rise before the issue is abandoned.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester; held until acked.
- chars  in  8*NREQ  requester i's byte on chars[8*i+7:8*i]; stable while req[i] high.
- ack  out  NREQ  one-cycle pulse: byte from requester i accepted.
- char  out  8  byte to transmitter.
- sendchar  out  1  one-cycle start strobe to transmitter.
- busy  in  1  transmitter busy.
- owner  out  $clog2(NREQ)  index of current/last granted requester.
- active  out  1  high from grant until frame done.
- drop  out  1  one-cycle pulse: busy never rose after sendchar (timeout).

Behaviour:
- Reset (reset=0, async): state IDLE, ptr=0, char=0, sendchar=0, ack=0, owner=0, active=0, drop=0, timer=0. All outputs take reset values immediately. A frame in flight is simply forgotten; the transmitter is reset by its own reset.
- States: IDLE, ISSUE, WAITBUSY, WAITDONE (one-hot).
- IDLE:
  - If any req bit is set and busy=0: select the first set bit scanning ptr, ptr+1, … wrapping mod NREQ.
  - Register owner, latch char from chars, set active=1, go to ISSUE.
  - If busy=1, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - sendchar=1 and ack[owner]=1 together.
  - ptr <= owner+1 (wraps NREQ-1→0).
  - timer <= BUSY_TMO; go to WAITBUSY.
- WAITBUSY:
  - busy=1 → WAITDONE.
  - Otherwise decrement timer. When timer reaches 0 with busy still 0: pulse drop, clear active, go to IDLE.
- WAITDONE:
  - busy=0 → clear active, go to IDLE.
  - Earliest next sendchar: 2 cycles after busy falls (IDLE, ISSUE).
- Latency: req[i] rising in IDLE with busy=0 and no competition gives sendchar 2 cycles later (grant edge, then ISSUE). The ack edge is the same cycle as sendchar.
- Requester rules:
  - A requester must drop req on the cycle after ack, or hold it to queue another byte.
  - A re-asserted or held req competes normally. Fairness comes from the ptr advance: with all NREQ requesting, grants rotate 0,1,2,3,0…
- Deasserting req before ack is allowed. If the winner is already latched, the byte is still sent. char is stable from grant through WAITDONE.
- sendchar is never asserted while busy=1 or outside ISSUE.
- Unused state encodings → IDLE.

Optional Feature:
- Macro UART_TX_ARB_LOCK_EN adds input `lock` (NREQ bits).
- With the macro: if lock[owner]=1 at the cycle the arbiter returns to IDLE, the next grant goes only to owner, whether or not others request. ptr does not advance on that issue. This keeps multi-byte packets contiguous.
- If owner's req is low while locked, the arbiter waits in IDLE.
- Lock is released when lock[owner]=0; normal round-robin then resumes from owner+1.
- Without the macro: no lock port, pure round-robin.

Decomposition:
- Package uart_pkg holds:
  - state localparams (IDLE/ISSUE/WAITBUSY/WAITDONE one-hot, 4 bits);
  - FRAME_BITS=10;
  - default OVERSAMPLE=16, shared with the transmitter.
- One natural sub-module: rr_pick. Combinational priority rotate: inputs req and ptr; outputs found and idx.

Test Plan:
- Single request: req=4'b0100, chars[23:16]=8'hA5, busy model rises 1 cycle after sendchar and holds 160 cycles → sendchar 2 cycles after req with char=8'hA5, ack=4'b0100 same cycle, owner=2, active low the cycle after busy falls.
- All four request continuously with bytes 8'h10,8'h11,8'h12,8'h13 → grant/ack order 0,1,2,3,0; exactly one sendchar per busy frame; never sendchar while busy=1.
- Transmitter never asserts busy → drop pulses BUSY_TMO+1 cycles after sendchar, arbiter back in IDLE, next requester granted.
- Reset driven low in WAITDONE mid-frame, then released → outputs zero asynchronously (same timestep); ptr=0; requester 0 wins first after release.
- busy=1 externally while req=4'b0001 → no grant until busy=0, then sendchar 2 cycles later.
- UART_TX_ARB_LOCK_EN: lock[1]=1 with req=4'b0011 → three consecutive grants to 1. Drop lock[1] → next grant to 0.
